vga_scan: RTL and testbench
===========================

VGA_SCAN -- requirements
Module: vga_scan

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter H_FRONT / H_SYNC / H_BACK, defaults 16 / 96 / 48, horizontal porch and sync widths in pixels.
REQ-003 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 Parameter V_FRONT / V_SYNC / V_BACK, defaults 10 / 2 / 33, vertical porch and sync widths in lines.
REQ-005 Parameter CLK_DIV, default 2, clk cycles per pixel; legal range 1..8.
REQ-006 Parameter PIPE_LATENCY, default 1, pixel ticks from x/y presented to pixel valid; legal range 0..4.
REQ-007 Parameter INT_WIDTH, default 16, coordinate width.
REQ-008 Parameter COLOR_WIDTH, default 12, pixel width (4R:4G:4B, R in MSBs).
REQ-009 clk  input  1  system clock; one clock domain; all state updates on rising edge.
REQ-010 rst  input  1  synchronous, active-high reset.
REQ-011 x  output  INT_WIDTH  current horizontal count, fed to the sprite cluster.
REQ-012 y  output  INT_WIDTH  current vertical count, fed to the sprite cluster.
REQ-013 pixel  input  COLOR_WIDTH  colour returned by the cluster for x/y, valid PIPE_LATENCY ticks later.
REQ-014 vga_r / vga_g / vga_b  output  4 each  registered colour to the DAC.
REQ-015 vga_hs / vga_vs  output  1 each  registered sync, active-low.
REQ-016 frame_start  output  1  one-clk pulse at the first tick of the first vertical blanking line.

Function
REQ-017 Divider counts 0..CLK_DIV-1; pixel tick asserted for one clk when the count equals CLK_DIV-1; CLK_DIV=1 means a tick every clk.
REQ-018 h_cnt advances on tick; wraps from H_TOTAL-1 (H_ACTIVE+H_FRONT+H_SYNC+H_BACK, default 800) to 0.
REQ-019 v_cnt advances on the tick where h_cnt wraps; wraps from V_TOTAL-1 (default 525) to 0.
REQ-020 x = h_cnt and y = v_cnt, zero-extended, in every cycle including blanking.
REQ-021 active = (h_cnt < H_ACTIVE) and (v_cnt < V_ACTIVE).
REQ-022 hs_raw is low when H_ACTIVE+H_FRONT <= h_cnt < H_ACTIVE+H_FRONT+H_SYNC; vs_raw uses the same rule on v_cnt.
REQ-023 active, hs_raw and vs_raw pass through a shift line PIPE_LATENCY ticks deep, advancing only on tick.
REQ-024 On tick, the output register loads vga_hs/vga_vs from the delayed syncs and loads {vga_r,vga_g,vga_b} from pixel when delayed active is 1, else 0.
REQ-025 Total x/y-to-pin latency is PIPE_LATENCY+1 ticks; colour and sync stay aligned.
REQ-026 Outputs hold between ticks.
REQ-027 frame_start pulses one clk on the tick where h_cnt becomes 0 and v_cnt becomes V_ACTIVE; there is exactly one pulse per frame.
REQ-028 The block has no handshake; pixel is sampled unconditionally on tick.

Reset
REQ-029 rst has priority over tick.
REQ-030 On rst: divider, h_cnt and v_cnt are 0; delay line is cleared to active=0, syncs=1; vga_r/g/b are 0; vga_hs and vga_vs are 1; frame_start is 0.
REQ-031 rst asserted mid-line or mid-frame takes effect the next edge; the first tick after release starts counting from (0,0).

Structure
REQ-032 Timing defaults (640x480@60 constants) and the RGB444 field split live in package gpu_pkg, shared with the cluster.
REQ-033 One sub-module, sync_counter (parameterised wrap counter with an enable and a wrap output), is instantiated for h and for v.
REQ-034 No memories; the delay line is flops.

Verification
REQ-035 CLK_DIV=2, after rst release -> first tick at clk 2 (counting from release); h_cnt=799 -> 0 with v_cnt incremented; v wraps at 525; period 800x525x2 clk.
REQ-036 Sync windows -> vga_hs low for exactly 96 ticks, starting PIPE_LATENCY+1 ticks after h_cnt=656; vga_vs low for 2 lines starting at line 490 (delayed likewise).
REQ-037 pixel = 12'hABC constant, PIPE_LATENCY=1 -> vga_r=A, vga_g=B, vga_b=C for pixels 0..639 of lines 0..479; 0 on all blanking pixels; first coloured tick is 2 ticks after x=0.
REQ-038 pixel = x[11:0] -> the colour on pin at tick n equals the x value from tick n-PIPE_LATENCY-1; repeat for PIPE_LATENCY=0 and PIPE_LATENCY=4.
REQ-039 frame_start -> exactly one 1-clk pulse per frame, coincident with x=0,y=480; none during rst.
REQ-040 rst pulsed at x=300,y=200 -> next edge gives x=0, y=0, hs=vs=1, rgb=0; the sequence resumes identically to power-on.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared GPU definitions: 640x480@60 timing defaults, RGB444 split,
// and the scan control bundle carried down the pixel delay line.
package gpu_pkg;

    localparam int H_ACTIVE_DEF    = 640;
    localparam int H_FRONT_DEF     = 16;
    localparam int H_SYNC_DEF      = 96;
    localparam int H_BACK_DEF      = 48;
    localparam int V_ACTIVE_DEF    = 480;
    localparam int V_FRONT_DEF     = 10;
    localparam int V_SYNC_DEF      = 2;
    localparam int V_BACK_DEF      = 33;
    localparam int INT_WIDTH_DEF   = 16;
    localparam int COLOR_WIDTH_DEF = 12;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    typedef struct packed {
        logic act;
        logic hs;
        logic vs;
    } scan_ctl_t;

    // Blanking with both syncs idle (high).
    localparam scan_ctl_t CTL_IDLE = '{act: 1'b0, hs: 1'b1, vs: 1'b1};

    function automatic rgb444_t split_rgb(input logic [11:0] c);
        return rgb444_t'(c);
    endfunction

endpackage

// File: rtl/vga_scan_if.sv
// Scan-position bus between the VGA scanner and the sprite cluster.
// master: drives x/y, takes pixel back. slave: the cluster side.
interface vga_scan_if
    import gpu_pkg::*;
#(
    parameter int INT_WIDTH   = INT_WIDTH_DEF,
    parameter int COLOR_WIDTH = COLOR_WIDTH_DEF
) ();

    logic [INT_WIDTH-1:0]   x;
    logic [INT_WIDTH-1:0]   y;
    logic [COLOR_WIDTH-1:0] pixel;

    modport master (
        output x,
        output y,
        input  pixel
    );

    modport slave (
        input  x,
        input  y,
        output pixel
    );

endinterface

// File: rtl/sync_counter.sv
// Wrap counter 0..MAX-1 advancing on en; wrap flags the enabled
// step from MAX-1 back to 0. Ports: clk, rst, en, cnt, wrap.
module sync_counter #(
    parameter int MAX = 800,
    parameter int W   = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    assign wrap = en && (cnt == W'(MAX - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vga_scan.sv
// VGA raster scanner: pixel-rate divider, h/v counters, x/y to the
// cluster over scan (vga_scan_if.master), delayed syncs + colour to
// vga_r/g/b, vga_hs/vs (active-low), frame_start pulse. clk, rst.
module vga_scan
    import gpu_pkg::*;
#(
    parameter int H_ACTIVE     = H_ACTIVE_DEF,
    parameter int H_FRONT      = H_FRONT_DEF,
    parameter int H_SYNC       = H_SYNC_DEF,
    parameter int H_BACK       = H_BACK_DEF,
    parameter int V_ACTIVE     = V_ACTIVE_DEF,
    parameter int V_FRONT      = V_FRONT_DEF,
    parameter int V_SYNC       = V_SYNC_DEF,
    parameter int V_BACK       = V_BACK_DEF,
    parameter int CLK_DIV      = 2,
    parameter int PIPE_LATENCY = 1,
    parameter int INT_WIDTH    = INT_WIDTH_DEF,
    parameter int COLOR_WIDTH  = COLOR_WIDTH_DEF
) (
    input  logic       clk,
    input  logic       rst,
    vga_scan_if.master scan,
    output logic [3:0] vga_r,
    output logic [3:0] vga_g,
    output logic [3:0] vga_b,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [INT_WIDTH-1:0] H_ACT = INT_WIDTH'(H_ACTIVE);
    localparam logic [INT_WIDTH-1:0] HS_LO = INT_WIDTH'(H_ACTIVE + H_FRONT);
    localparam logic [INT_WIDTH-1:0] HS_HI = INT_WIDTH'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [INT_WIDTH-1:0] V_ACT = INT_WIDTH'(V_ACTIVE);
    localparam logic [INT_WIDTH-1:0] V_PRE = INT_WIDTH'(V_ACTIVE - 1);
    localparam logic [INT_WIDTH-1:0] VS_LO = INT_WIDTH'(V_ACTIVE + V_FRONT);
    localparam logic [INT_WIDTH-1:0] VS_HI = INT_WIDTH'(V_ACTIVE + V_FRONT + V_SYNC);

    logic [2:0]           div_cnt;
    logic                 tick;
    logic [INT_WIDTH-1:0] h_cnt;
    logic [INT_WIDTH-1:0] v_cnt;
    logic                 h_wrap;
    logic                 unused_v_wrap;
    scan_ctl_t            raw;
    scan_ctl_t            dctl;
    rgb444_t              px;

    // Pixel-rate divider.
    assign tick = (div_cnt == 3'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 3'd1;
        end
    end

    sync_counter #(
        .MAX (H_TOTAL),
        .W   (INT_WIDTH)
    ) u_h_cnt (
        .clk  (clk),
        .rst  (rst),
        .en   (tick),
        .cnt  (h_cnt),
        .wrap (h_wrap)
    );

    sync_counter #(
        .MAX (V_TOTAL),
        .W   (INT_WIDTH)
    ) u_v_cnt (
        .clk  (clk),
        .rst  (rst),
        .en   (h_wrap),
        .cnt  (v_cnt),
        .wrap (unused_v_wrap)
    );

    assign scan.x = h_cnt;
    assign scan.y = v_cnt;

    assign raw.act = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign raw.hs  = !((h_cnt >= HS_LO) && (h_cnt < HS_HI));
    assign raw.vs  = !((v_cnt >= VS_LO) && (v_cnt < VS_HI));

    // Control is delayed to line up with the cluster's pixel latency.
    generate
        if (PIPE_LATENCY == 0) begin : g_nodly
            assign dctl = raw;
        end else begin : g_dly
            scan_ctl_t [PIPE_LATENCY-1:0] line;

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < PIPE_LATENCY; i++) begin
                        line[i] <= CTL_IDLE;
                    end
                end else if (tick) begin
                    for (int i = PIPE_LATENCY - 1; i > 0; i--) begin
                        line[i] <= line[i-1];
                    end
                    line[0] <= raw;
                end
            end

            assign dctl = line[PIPE_LATENCY-1];
        end
    endgenerate

    assign px = split_rgb(scan.pixel[11:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            // v_cnt steps to V_ACTIVE on this very tick.
            frame_start <= h_wrap && (v_cnt == V_PRE);
            if (tick) begin
                vga_hs <= dctl.hs;
                vga_vs <= dctl.vs;
                vga_r  <= dctl.act ? px.r : 4'd0;
                vga_g  <= dctl.act ? px.g : 4'd0;
                vga_b  <= dctl.act ? px.b : 4'd0;
            end
        end
    end

endmodule

// File: tb/tb_vga_scan.sv
// Self-checking bench for vga_scan: three configurations checked every
// clk against a closed-form timing model with random cluster colours.
module tb_vga_scan;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   chk_en = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s @%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    for (genvar G = 0; G < 3; G++) begin : g_cfg
        localparam int HA = (G == 0) ? 640 : 16;
        localparam int HF = (G == 0) ? 16 : 2;
        localparam int HS = (G == 0) ? 96 : 3;
        localparam int HB = (G == 0) ? 48 : 3;
        localparam int VA = (G == 0) ? 480 : 6;
        localparam int VF = (G == 0) ? 10 : 1;
        localparam int VS = 2;
        localparam int VB = (G == 0) ? 33 : 1;
        localparam int D  = (G == 0) ? 2 : (G == 1) ? 3 : 1;
        localparam int P  = (G == 0) ? 1 : (G == 1) ? 0 : 4;
        localparam int HT = HA + HF + HS + HB;
        localparam int VT = VA + VF + VS + VB;

        logic [3:0]  r, g, b;
        logic        hs, vs, fs;
        int          rc;
        int          hx [0:4];
        int          hy [0:4];
        logic [11:0] tbl [0:255];
        logic [11:0] pix;

        vga_scan_if #(.INT_WIDTH(16), .COLOR_WIDTH(12)) scan ();

        vga_scan #(
            .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
            .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
            .CLK_DIV(D), .PIPE_LATENCY(P),
            .INT_WIDTH(16), .COLOR_WIDTH(12)
        ) dut (
            .clk         (clk),
            .rst         (rst),
            .scan        (scan),
            .vga_r       (r),
            .vga_g       (g),
            .vga_b       (b),
            .vga_hs      (hs),
            .vga_vs      (vs),
            .frame_start (fs)
        );

        initial begin
            for (int i = 0; i < 256; i++) tbl[i] = 12'($urandom);
        end

        // Cluster: colour for the x/y it saw P pixel ticks ago.
        always_comb begin
            int sx, sy;
            sx = (P == 0) ? int'(scan.x) : hx[P];
            sy = (P == 0) ? int'(scan.y) : hy[P];
            pix = 12'h000;
            if (G == 0) pix = 12'hABC;
            else if (sx < HT && sy < VT) pix = tbl[sy*HT + sx];
        end
        assign scan.pixel = pix;

        always @(posedge clk) begin
            if (rst) begin
                rc <= 0;
                for (int i = 0; i <= 4; i++) begin
                    hx[i] <= 0;
                    hy[i] <= 0;
                end
            end else begin
                if ((rc + 1) % D == 0) begin
                    hx[1] <= int'(scan.x);
                    hy[1] <= int'(scan.y);
                    for (int i = 2; i <= 4; i++) begin
                        hx[i] <= hx[i-1];
                        hy[i] <= hy[i-1];
                    end
                end
                rc <= rc + 1;
            end
        end

        // Model: after rc clk since release, T pixel ticks have occurred;
        // the pins show the raster position from tick T-1-P.
        always @(negedge clk) begin
            int t, k, pos, h, v, kh, kv;
            bit act, ehs, evs, efs;
            logic [11:0] col;
            if (chk_en) begin
                t   = rc / D;
                pos = t % (HT * VT);
                h   = pos % HT;
                v   = pos / HT;
                k   = t - 1 - P;
                act = 1'b0;
                ehs = 1'b1;
                evs = 1'b1;
                col = 12'h000;
                if (k >= 0) begin
                    kh  = (k % (HT * VT)) % HT;
                    kv  = (k % (HT * VT)) / HT;
                    act = (kh < HA) && (kv < VA);
                    ehs = !(kh >= HA + HF && kh < HA + HF + HS);
                    evs = !(kv >= VA + VF && kv < VA + VF + VS);
                    if (act) col = (G == 0) ? 12'hABC : tbl[kv*HT + kh];
                end
                efs = (rc > 0) && (rc % D == 0) && (h == 0) && (v == VA);
                check($sformatf("g%0d.x", G), 32'(scan.x), 32'(h));
                check($sformatf("g%0d.y", G), 32'(scan.y), 32'(v));
                check($sformatf("g%0d.rgb", G), 32'({r, g, b}), 32'(col));
                check($sformatf("g%0d.hs", G), 32'(hs), 32'(ehs));
                check($sformatf("g%0d.vs", G), 32'(vs), 32'(evs));
                check($sformatf("g%0d.frame_start", G), 32'(fs), 32'(efs));
            end
        end
    end

    task automatic pulse_rst(input int n);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        @(posedge clk);
        #1 chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4000) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            pulse_rst($urandom_range(1, 3));
            repeat ($urandom_range(300, 1800)) @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
